// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin sharing of one combinational ALU between two
//               valid/ready requesters, with a registered valid/ready response.
// Revision    : 1.0 - initial release
// ============================================================================

module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [SEL_W-1:0]  req0_sel,
    input  logic              req0_cin,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [SEL_W-1:0]  req1_sel,
    input  logic              req1_cin,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    output logic              alu_cin,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [3:0]        alu_stat,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_out,
    output logic [3:0]        rsp_stat
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q,      state_d;
    logic                last_grant_q, last_grant_d;
    logic [DATA_W-1:0]   a_q,          a_d;
    logic [DATA_W-1:0]   b_q,          b_d;
    logic [SEL_W-1:0]    sel_q,        sel_d;
    logic                cin_q,        cin_d;
    logic                rsp_valid_q,  rsp_valid_d;
    logic                rsp_id_q,     rsp_id_d;
    logic [DATA_W-1:0]   rsp_out_q,    rsp_out_d;
    logic [3:0]          rsp_stat_q,   rsp_stat_d;

    logic                w_grant0;
    logic                w_grant1;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        sel_d        = sel_q;
        cin_d        = cin_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_out_d    = rsp_out_q;
        rsp_stat_d   = rsp_stat_q;
        w_grant0     = 1'b0;
        w_grant1     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // On a tie the requester that was not served last wins.
                w_grant0 = req0_valid && (!req1_valid || last_grant_q);
                w_grant1 = req1_valid && (!req0_valid || !last_grant_q);
                if (w_grant0) begin
                    a_d          = req0_a;
                    b_d          = req0_b;
                    sel_d        = req0_sel;
                    cin_d        = req0_cin;
                    last_grant_d = 1'b0;
                    rsp_id_d     = 1'b0;
                    state_d      = S_EXEC;
                end else if (w_grant1) begin
                    a_d          = req1_a;
                    b_d          = req1_b;
                    sel_d        = req1_sel;
                    cin_d        = req1_cin;
                    last_grant_d = 1'b1;
                    rsp_id_d     = 1'b1;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_out_d   = alu_out;
                rsp_stat_d  = alu_stat;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            sel_q        <= '0;
            cin_q        <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_out_q    <= '0;
            rsp_stat_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sel_q        <= sel_d;
            cin_q        <= cin_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_out_q    <= rsp_out_d;
            rsp_stat_q   <= rsp_stat_d;
        end
    end

    // Operand registers feed the ALU directly and keep their value after the op.
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_sel    = sel_q;
    assign alu_cin    = cin_q;

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_out    = rsp_out_q;
    assign rsp_stat   = rsp_stat_q;

endmodule

`default_nettype wire
